// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the sudoku solver datapath.
//   cell_mask_t     : 9-bit candidate mask, bit d-1 set means digit d is possible
//   ALL_CANDIDATES  : mask for an empty cell
//   status_e        : solve outcome reported by grid_solve_ctrl
//   grid_state_e    : grid_solve_ctrl FSM states
//   digit_to_mask / mask_to_digit / is_onehot : cell encoding helpers
package sudoku_pkg;

    typedef logic [8:0] cell_mask_t;

    localparam cell_mask_t ALL_CANDIDATES = 9'h1FF;

    typedef enum logic [1:0] {
        ST_NONE    = 2'd0,
        ST_SOLVED  = 2'd1,
        ST_STALLED = 2'd2,
        ST_CONTRA  = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_CHECK,
        S_DONE,
        S_READ
    } grid_state_e;

    function automatic logic is_onehot(input cell_mask_t m);
        return (m != '0) && ((m & (m - cell_mask_t'(1))) == '0);
    endfunction

    // Digits outside 1..9 (including 10..15) are treated as an empty cell.
    function automatic cell_mask_t digit_to_mask(input logic [3:0] d);
        cell_mask_t m;
        if (d >= 4'd1 && d <= 4'd9)
            m = cell_mask_t'(1) << (d - 4'd1);
        else
            m = ALL_CANDIDATES;
        return m;
    endfunction

    // Only a resolved (one-hot) cell yields a digit; anything else reads as 0.
    function automatic logic [3:0] mask_to_digit(input cell_mask_t m);
        logic [3:0] d;
        d = 4'd0;
        if (is_onehot(m)) begin
            for (int i = 0; i < 9; i++) begin
                if (m[i])
                    d = 4'(i + 1);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/grid_solve_ctrl_flags.sv
// Combinational reduction over all 81 cell masks.
//   grid       : candidate grid indexed [x][y][bit]
//   all_onehot : every cell resolved to exactly one digit
//   any_zero   : at least one cell has no candidates left
module grid_flags
    import sudoku_pkg::*;
(
    input  logic [8:0][8:0][8:0] grid,
    output logic                 all_onehot,
    output logic                 any_zero
);

    always_comb begin
        all_onehot = 1'b1;
        any_zero   = 1'b0;
        for (int x = 0; x < 9; x++) begin
            for (int y = 0; y < 9; y++) begin
                if (!is_onehot(grid[x][y]))
                    all_onehot = 1'b0;
                if (grid[x][y] == '0)
                    any_zero = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grid_solve_ctrl.sv
// Solve controller: owns the candidate grid presented to the Scanner, loads a
// puzzle as a row-major digit stream, repeatedly merges the Scanner's
// box-ordered result back into the grid, then streams the result out.
//   i_Clk, i_Rst_n             : clock, asynchronous active-low reset
//   i_Start                    : begin a new puzzle load (IDLE only)
//   i_Load_Valid/Digit, o_Load_Ready : load stream, one cell per handshake
//   o_Grid [x][y]              : registered grid driven to the Scanner
//   i_Box_Grid [bx][by][k]     : Scanner result, i_Complete its solved flag
//   o_Busy, o_Done, o_Status, o_Iter : progress and outcome
//   o_Rd_Valid/Digit, i_Rd_Ready     : readout stream, one cell per handshake
module grid_solve_ctrl
    import sudoku_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_ITER      = 64
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_n,
    input  logic                      i_Start,
    input  logic                      i_Load_Valid,
    input  logic [3:0]                i_Load_Digit,
    output logic                      o_Load_Ready,
    output logic [8:0][8:0][8:0]      o_Grid,
    input  logic [2:0][2:0][8:0][8:0] i_Box_Grid,
    input  logic                      i_Complete,
    output logic                      o_Busy,
    output logic                      o_Done,
    output logic [1:0]                o_Status,
    output logic [7:0]                o_Iter,
    output logic                      o_Rd_Valid,
    output logic [3:0]                o_Rd_Digit,
    input  logic                      i_Rd_Ready
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    grid_state_e          state, state_nxt;
    logic [3:0]           cell_x, cell_y;
    logic [CNT_W-1:0]     settle_cnt;
    logic                 changed;
    status_e              status_q;
    logic [8:0][8:0][8:0] remap;
    logic [8:0][8:0][8:0] merged;
    logic                 all_onehot, any_zero;
    logic                 load_hs, rd_hs, last_cell;

    assign load_hs   = (state == S_LOAD) && i_Load_Valid;
    assign rd_hs     = (state == S_READ) && i_Rd_Ready;
    assign last_cell = (cell_x == 4'd8) && (cell_y == 4'd8);

    assign o_Load_Ready = (state == S_LOAD);
    assign o_Busy       = (state != S_IDLE);
    assign o_Done       = (state == S_DONE);
    assign o_Rd_Valid   = (state == S_READ);
    assign o_Rd_Digit   = (state == S_READ) ? mask_to_digit(o_Grid[cell_x][cell_y]) : 4'd0;
    assign o_Status     = status_q;

    // Box cell k sits at column k%3, row k/3 inside box (bx, by).
    always_comb begin
        remap = '0;
        for (int bx = 0; bx < 3; bx++) begin
            for (int by = 0; by < 3; by++) begin
                for (int k = 0; k < 9; k++) begin
                    remap[bx*3 + k%3][by*3 + k/3] = i_Box_Grid[bx][by][k];
                end
            end
        end
    end

    // Intersection only: the Scanner can eliminate candidates but never add them.
    assign merged = o_Grid & remap;

    grid_flags u_flags (
        .grid       (o_Grid),
        .all_onehot (all_onehot),
        .any_zero   (any_zero)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (i_Start) state_nxt = S_LOAD;
            S_LOAD:    if (load_hs && last_cell) state_nxt = S_SETTLE;
            S_SETTLE:  if (settle_cnt <= CNT_W'(1)) state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = S_CHECK;
            S_CHECK: begin
                if (any_zero || all_onehot || i_Complete || !changed ||
                    o_Iter == 8'(MAX_ITER))
                    state_nxt = S_DONE;
                else
                    state_nxt = S_SETTLE;
            end
            S_DONE:    state_nxt = S_READ;
            S_READ:    if (rd_hs && last_cell) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Grid     <= {81{ALL_CANDIDATES}};
            cell_x     <= 4'd0;
            cell_y     <= 4'd0;
            settle_cnt <= '0;
            changed    <= 1'b0;
            status_q   <= ST_NONE;
            o_Iter     <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_Start) begin
                        status_q <= ST_NONE;
                        o_Iter   <= 8'd0;
                        cell_x   <= 4'd0;
                        cell_y   <= 4'd0;
                    end
                end
                S_LOAD: begin
                    if (load_hs) begin
                        o_Grid[cell_x][cell_y] <= digit_to_mask(i_Load_Digit);
                        if (last_cell)
                            settle_cnt <= CNT_W'(SETTLE_CYCLES);
                        if (cell_x == 4'd8) begin
                            cell_x <= 4'd0;
                            cell_y <= (cell_y == 4'd8) ? 4'd0 : cell_y + 4'd1;
                        end else begin
                            cell_x <= cell_x + 4'd1;
                        end
                    end
                end
                S_SETTLE: settle_cnt <= settle_cnt - CNT_W'(1);
                S_CAPTURE: begin
                    o_Grid  <= merged;
                    changed <= (merged != o_Grid);
                    o_Iter  <= o_Iter + 8'd1;
                end
                S_CHECK: begin
                    if (any_zero)
                        status_q <= ST_CONTRA;
                    else if (all_onehot || i_Complete)
                        status_q <= ST_SOLVED;
                    else if (!changed || o_Iter == 8'(MAX_ITER))
                        status_q <= ST_STALLED;
                    else
                        settle_cnt <= CNT_W'(SETTLE_CYCLES);
                end
                S_DONE: begin
                    cell_x <= 4'd0;
                    cell_y <= 4'd0;
                end
                S_READ: begin
                    if (rd_hs) begin
                        if (cell_x == 4'd8) begin
                            cell_x <= 4'd0;
                            cell_y <= (cell_y == 4'd8) ? 4'd0 : cell_y + 4'd1;
                        end else begin
                            cell_x <= cell_x + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_solve_ctrl.sv
// Directed bench for grid_solve_ctrl with a behavioural Scanner model.
module tb_grid_solve_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, start2, load_valid, rd_ready, complete;
    logic [3:0] load_digit;

    logic                      load_ready, busy, done, rd_valid;
    logic [1:0]                status;
    logic [7:0]                iter;
    logic [3:0]                rd_digit;
    logic [8:0][8:0][8:0]      grid;
    logic [2:0][2:0][8:0][8:0] box;

    logic                      load_ready2, busy2, done2, rd_valid2;
    logic [1:0]                status2;
    logic [7:0]                iter2;
    logic [3:0]                rd_digit2;
    logic [8:0][8:0][8:0]      grid2;
    logic [2:0][2:0][8:0][8:0] box2;

    int scan_mode;
    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] puz[81];
    logic [3:0] exp_rd[81];

    grid_solve_ctrl #(.SETTLE_CYCLES(2), .MAX_ITER(64)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start),
        .i_Load_Valid(load_valid), .i_Load_Digit(load_digit), .o_Load_Ready(load_ready),
        .o_Grid(grid), .i_Box_Grid(box), .i_Complete(complete),
        .o_Busy(busy), .o_Done(done), .o_Status(status), .o_Iter(iter),
        .o_Rd_Valid(rd_valid), .o_Rd_Digit(rd_digit), .i_Rd_Ready(rd_ready)
    );

    grid_solve_ctrl #(.SETTLE_CYCLES(1), .MAX_ITER(3)) dut2 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start2),
        .i_Load_Valid(load_valid), .i_Load_Digit(load_digit), .o_Load_Ready(load_ready2),
        .o_Grid(grid2), .i_Box_Grid(box2), .i_Complete(1'b0),
        .o_Busy(busy2), .o_Done(done2), .o_Status(status2), .o_Iter(iter2),
        .o_Rd_Valid(rd_valid2), .o_Rd_Digit(rd_digit2), .i_Rd_Ready(rd_ready)
    );

    // Scanner model. Mode 0 echoes the grid back in box order (cell (x,y)
    // lands in box (x/3, y/3) at k = 3*(y%3) + x%3); other modes return all
    // candidates except for one chosen box cell.
    always_comb begin
        box = '1;
        case (scan_mode)
            0: begin
                for (int x = 0; x < 9; x++)
                    for (int y = 0; y < 9; y++)
                        box[x/3][y/3][(y%3)*3 + x%3] = grid[x][y];
            end
            2: box[1][2][5] = 9'h004;
            3: box[2][1][4] = 9'h000;
            default: ;
        endcase
    end

    // Second model strips the top candidate from cell (0,0) every pass.
    always_comb begin
        box2 = '1;
        box2[0][0][0] = grid2[0][0] >> 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic int count_not_full(input logic [8:0][8:0][8:0] g);
        int c;
        c = 0;
        for (int x = 0; x < 9; x++)
            for (int y = 0; y < 9; y++)
                if (g[x][y] != 9'h1FF) c++;
        return c;
    endfunction

    function automatic logic [3:0] solved_digit(input int n);
        int x, y;
        x = n % 9;
        y = n / 9;
        return 4'(((y*3 + y/3 + x) % 9) + 1);
    endfunction

    // Starts a load and feeds puz[0..count-1]; returns on a negedge.
    task automatic load_cells(input int count, input bit to2);
        @(negedge clk);
        if (to2) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start2 = 1'b0;
        for (int i = 0; i < count; i++) begin
            load_valid = 1'b1;
            load_digit = puz[i];
            if (i == 0) check("load_ready", to2 ? load_ready2 : load_ready, 1);
            @(negedge clk);
        end
        load_valid = 1'b0;
    endtask

    task automatic wait_done(input bit to2);
        int t;
        t = 0;
        while (t < 500 && !(to2 ? done2 : done)) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("done_timeout", 0, 1);
    endtask

    // Called on the negedge right after the DONE cycle.
    task automatic read_all();
        check("rd_valid", rd_valid, 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 81; i++) begin
            if (i == 40) begin
                rd_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("rd_hold", rd_digit, exp_rd[40]);
                end
                rd_ready = 1'b1;
            end
            check($sformatf("rd%0d", i), rd_digit, exp_rd[i]);
            @(negedge clk);
        end
        rd_ready = 1'b0;
        check("idle_after_read", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; load_valid = 1'b0;
        load_digit = 4'd0; rd_ready = 1'b0; complete = 1'b0; scan_mode = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_status", status, 0);
        check("rst_iter", iter, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_digit", rd_digit, 0);
        check("rst_grid", count_not_full(grid), 0);
        rst_n = 1'b1;

        // Reset during load: 40 cells of a solved puzzle, then pull reset
        for (int n = 0; n < 81; n++) begin
            puz[n] = solved_digit(n);
            exp_rd[n] = solved_digit(n);
        end
        load_cells(40, 1'b0);
        check("midload_ready", load_ready, 1);
        rst_n = 1'b0;
        #1;
        check("arst_ready", load_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_grid", count_not_full(grid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Solved puzzle with echo model
        scan_mode = 0;
        load_cells(81, 1'b0);
        wait_done(1'b0);
        check("solved_status", status, 1);
        check("solved_iter", iter, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        read_all();
        check("status_held", status, 1);
        check("iter_held", iter, 1);

        // Empty puzzle, model returns all candidates
        scan_mode = 1;
        for (int n = 0; n < 81; n++) begin
            puz[n] = (n % 2 == 0) ? 4'd0 : 4'd12;
            exp_rd[n] = 4'd0;
        end
        load_cells(81, 1'b0);
        wait_done(1'b0);
        check("stall_status", status, 2);
        check("stall_iter", iter, 1);
        @(negedge clk);
        read_all();

        // Single eliminated box cell: box (1,2) k=5 is cell x=5, y=7
        scan_mode = 2;
        for (int n = 0; n < 81; n++) puz[n] = 4'd0;
        exp_rd[68] = 4'd3;
        load_cells(81, 1'b0);
        begin
            int t;
            t = 0;
            while (t < 100 && iter != 8'd1) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) check("iter1_timeout", 0, 1);
        end
        check("remap_cell", grid[5][7], 9'h004);
        check("remap_others", count_not_full(grid), 1);
        wait_done(1'b0);
        check("remap_status", status, 2);
        check("remap_iter", iter, 2);
        @(negedge clk);
        read_all();

        // Contradiction wins even with complete asserted
        scan_mode = 3;
        complete = 1'b1;
        exp_rd[68] = 4'd0;
        load_cells(81, 1'b0);
        wait_done(1'b0);
        check("contra_status", status, 3);
        check("contra_iter", iter, 1);
        @(negedge clk);
        read_all();
        complete = 1'b0;

        // Iteration limit on the MAX_ITER=3 instance
        load_cells(81, 1'b1);
        wait_done(1'b1);
        check("maxit_status", status2, 2);
        check("maxit_iter", iter2, 3);
        check("maxit_cell", grid2[0][0], 9'h03F);
        check("dut1_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
